// File: rtl/geofence_pkg.sv
// Shared geofence types and constants for the cross-product arbiter slice.
// Point layout: {Y, X}; job layout: {p4, p3, p2, p1}, with p1 in the low bits.
package geofence_pkg;

  localparam int CW_DEF = 10;

  typedef struct packed {
    logic [CW_DEF-1:0] y;
    logic [CW_DEF-1:0] x;
  } point_t;

  typedef struct packed {
    logic signed [CW_DEF:0] y;
    logic signed [CW_DEF:0] x;
  } vec_t;

  // Declared p4-first so that p1 occupies the least-significant bits.
  typedef struct packed {
    point_t p4;
    point_t p3;
    point_t p2;
    point_t p1;
  } job_t;

endpackage

// File: rtl/cross_pipe.sv
// Two-stage cross-product sign engine.
// Stage 1 captures the edge vectors and the tag.
// Stage 2 multiplies, compares, and decodes the tag to a one-hot pulse.
// The optional rsp_zero flag is built only when CROSS_ZERO_FLAG_EN is defined.
module cross_pipe
  import geofence_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEF,
  parameter int TW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [TW-1:0]     in_tag,
  input  logic [8*CW-1:0]   in_job,
  output logic [NREQ-1:0]   out_valid,
  output logic              out_pos,
  output logic              busy
`ifdef CROSS_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);

  localparam int PW = 2 * CW;

  // Coordinates are unsigned, so zero-extend by one bit before subtracting.
  function automatic logic signed [CW:0] axis_diff(input logic [CW-1:0] a,
                                                   input logic [CW-1:0] b);
    axis_diff = $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  logic [CW-1:0] p1x, p1y, p2x, p2y, p3x, p3y, p4x, p4y;

  assign p1x = in_job[0*PW      +: CW];
  assign p1y = in_job[0*PW + CW +: CW];
  assign p2x = in_job[1*PW      +: CW];
  assign p2y = in_job[1*PW + CW +: CW];
  assign p3x = in_job[2*PW      +: CW];
  assign p3y = in_job[2*PW + CW +: CW];
  assign p4x = in_job[3*PW      +: CW];
  assign p4y = in_job[3*PW + CW +: CW];

  logic                 s1_valid;
  logic [TW-1:0]        s1_tag;
  logic signed [CW:0]   ax, ay, bx, by;
  logic signed [2*CW+1:0] lhs, rhs;

  // (CW+1)x(CW+1) signed products fit exactly in 2CW+2 bits, so they cannot overflow.
  always_comb begin
    lhs = ax * by;
    rhs = bx * ay;
  end

  // Stage 1: capture the edge vectors vA = p2 - p1 and vB = p4 - p3, plus the tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      ax       <= '0;
      ay       <= '0;
      bx       <= '0;
      by       <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_tag   <= in_tag;
      ax       <= axis_diff(p2x, p1x);
      ay       <= axis_diff(p2y, p1y);
      bx       <= axis_diff(p4x, p3x);
      by       <= axis_diff(p4y, p3y);
    end
  end

  // Stage 2: register the sign result and the one-hot return pulse.
  // busy tracks the next-state occupancy, so it mirrors the current stage valids.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      out_pos   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= s1_valid ? ({{(NREQ-1){1'b0}}, 1'b1} << s1_tag) : '0;
      out_pos   <= (lhs > rhs);
      busy      <= in_valid | s1_valid;
    end
  end

`ifdef CROSS_ZERO_FLAG_EN
  // Equality flag marks points lying exactly on an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_zero <= 1'b0;
    end else begin
      out_zero <= (lhs == rhs);
    end
  end
`endif

endmodule

// File: rtl/cross_rr_arbiter.sv
// Round-robin front end sharing one cross_pipe engine among NREQ requesters.
// The optional rsp_zero output is present only when CROSS_ZERO_FLAG_EN is defined.
module cross_rr_arbiter
  import geofence_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = CW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*8*CW-1:0] req_pts,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_pos,
  output logic                 busy
`ifdef CROSS_ZERO_FLAG_EN
  ,
  output logic                 rsp_zero
`endif
);

  localparam int TW = $clog2(NREQ);
  localparam int JW = 8 * CW;

  logic [TW-1:0]   ptr;
  logic [TW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [JW-1:0]   gnt_job;

  // Search upward from the pointer with wraparound; the first active request wins.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any        = 1'b1;
        req_ready[idx] = 1'b1;
        gnt_idx        = TW'(idx);
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

  assign gnt_job = req_pts[int'(gnt_idx)*JW +: JW];

  // After a grant, move the pointer just past the winner; with no grant, hold it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      if (gnt_idx == TW'(NREQ-1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt_idx + 1'b1;
      end
    end else begin
      ptr <= ptr;
    end
  end

  cross_pipe #(
    .NREQ (NREQ),
    .CW   (CW),
    .TW   (TW)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (gnt_any),
    .in_tag    (gnt_idx),
    .in_job    (gnt_job),
    .out_valid (rsp_valid),
    .out_pos   (rsp_pos),
    .busy      (busy)
`ifdef CROSS_ZERO_FLAG_EN
    ,
    .out_zero  (rsp_zero)
`endif
  );

endmodule

// File: tb/tb_cross_rr_arbiter.sv
// Directed self-checking bench for cross_rr_arbiter; rsp_zero is checked
// only when CROSS_ZERO_FLAG_EN is defined.
module tb_cross_rr_arbiter;
  import geofence_pkg::*;

  localparam int NREQ = 4;
  localparam int CW   = CW_DEF;
  localparam int JW   = 8 * CW;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*JW-1:0]   req_pts;
  logic [NREQ-1:0]      rsp_valid;
  logic                 rsp_pos;
  logic                 busy;
`ifdef CROSS_ZERO_FLAG_EN
  logic                 rsp_zero;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  cross_rr_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pts   (req_pts),
    .rsp_valid (rsp_valid),
    .rsp_pos   (rsp_pos),
    .busy      (busy)
`ifdef CROSS_ZERO_FLAG_EN
    ,
    .rsp_zero  (rsp_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic job_t mkjob(input int x1, input int y1, input int x2, input int y2,
                                 input int x3, input int y3, input int x4, input int y4);
    job_t j;
    j.p1.x = CW'(x1); j.p1.y = CW'(y1);
    j.p2.x = CW'(x2); j.p2.y = CW'(y2);
    j.p3.x = CW'(x3); j.p3.y = CW'(y3);
    j.p4.x = CW'(x4); j.p4.y = CW'(y4);
    return j;
  endfunction

  // One isolated job: grant check, then the two-cycle result, then idle.
  task automatic single(input string tag, input int r, input job_t j,
                        input logic ep, input logic ez);
    req_pts[r*JW +: JW] = j;
    req_valid = 4'b0001 << r;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << r));
    @(negedge clk);
    req_valid = 4'b0000;
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    chk({tag, "_norsp"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'(4'b0001 << r));
    chk({tag, "_pos"}, 32'(rsp_pos), 32'(ep));
`ifdef CROSS_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(rsp_zero), 32'(ez));
`else
    if (ez !== ez) chk({tag, "_ez"}, 32'(ez), 32'(ez));
`endif
    @(negedge clk);
    chk({tag, "_idle_rsp"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  job_t right_j, swap_j, coll_j, ext_j;
  logic [3:0] epos;
  logic [3:0] ezero;

  initial begin
    right_j = mkjob(0, 0, 10, 0, 0, 0, 0, 10);    // lhs=100, rhs=0
    swap_j  = mkjob(0, 0, 0, 10, 0, 0, 10, 0);    // lhs=0, rhs=100
    coll_j  = mkjob(0, 0, 5, 5, 0, 0, 2, 2);      // lhs=rhs=10
    ext_j   = mkjob(1023, 1023, 0, 0, 0, 0, 1023, 0); // lhs=0, rhs=-1046529

    reset     = 1'b1;
    req_valid = '0;
    req_pts   = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_pos", 32'(rsp_pos), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef CROSS_ZERO_FLAG_EN
    chk("rst_zero", 32'(rsp_zero), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Isolated jobs; the last grant goes to requester 1, leaving the pointer at 2.
    single("right", 0, right_j, 1'b1, 1'b0);
    single("swap", 0, swap_j, 1'b0, 1'b0);
    single("coll", 2, coll_j, 1'b0, 1'b1);
    single("ext", 1, ext_j, 1'b1, 1'b0);

    // Requesters 1 and 3 only, with the pointer at 2: expect grants 3, 1, 3.
    req_pts[1*JW +: JW] = swap_j;
    req_pts[3*JW +: JW] = right_j;
    req_valid = 4'b1010;
    #1;
    chk("pair_g0", 32'(req_ready), 32'(4'b1000));
    @(negedge clk);
    chk("pair_g1", 32'(req_ready), 32'(4'b0010));
    chk("pair_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("pair_g2", 32'(req_ready), 32'(4'b1000));
    chk("pair_r0", 32'(rsp_valid), 32'(4'b1000));
    chk("pair_p0", 32'(rsp_pos), 32'd1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("pair_noready", 32'(req_ready), 32'd0);
    chk("pair_r1", 32'(rsp_valid), 32'(4'b0010));
    chk("pair_p1", 32'(rsp_pos), 32'd0);
    @(negedge clk);
    chk("pair_r2", 32'(rsp_valid), 32'(4'b1000));
    chk("pair_p2", 32'(rsp_pos), 32'd1);
    @(negedge clk);
    chk("pair_idle", 32'(rsp_valid), 32'd0);
    chk("pair_idle_busy", 32'(busy), 32'd0);

    // All four requesting continuously; the pointer is back at 0.
    req_pts[0*JW +: JW] = right_j;
    req_pts[1*JW +: JW] = swap_j;
    req_pts[2*JW +: JW] = ext_j;
    req_pts[3*JW +: JW] = coll_j;
    epos  = 4'b0101;
    ezero = 4'b1000;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("cont_g%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 1) chk($sformatf("cont_busy%0d", k), 32'(busy), 32'd1);
      else chk("cont_busy_first", 32'(busy), 32'd0);
      if (k >= 2) begin
        chk($sformatf("cont_r%0d", k), 32'(rsp_valid), 32'(4'b0001 << ((k - 2) % 4)));
        chk($sformatf("cont_p%0d", k), 32'(rsp_pos), 32'(epos[(k - 2) % 4]));
`ifdef CROSS_ZERO_FLAG_EN
        chk($sformatf("cont_z%0d", k), 32'(rsp_zero), 32'(ezero[(k - 2) % 4]));
`endif
      end else begin
        chk($sformatf("cont_r%0d", k), 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
    end

    // Two jobs are in flight now; reset must discard them and rewind the pointer.
    reset     = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("mrst_rspv", 32'(rsp_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("mrst_rspv2", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rspv%0d", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("post_busy%0d", k), 32'(busy), 32'd0);
    end
    req_valid = 4'b1111;
    #1;
    chk("post_tie", 32'(req_ready), 32'(4'b0001));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    chk("post_tie_rsp", 32'(rsp_valid), 32'(4'b0001));
    chk("post_tie_pos", 32'(rsp_pos), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
